// File: rtl/dmac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmac_pkg                                               |
// | Description : Shared types, constants and burst sizing helper for    |
// |               the DMAC copy engine.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dmac_pkg;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    RAR   = 2'd1,
    RDAT  = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WIDLE = 2'd0,
    WAW   = 2'd1,
    WDAT  = 2'd2,
    WRSP  = 2'd3
  } wr_state_t;

  localparam int MAX_BURST_BEATS = 16;
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BEAT_BYTES      = DATA_WIDTH_DFLT / 8;

  // Beats in the next burst: whatever is left, capped at one 16-beat burst.
  function automatic logic [4:0] burst_beats(input logic [31:0] remain);
    if (remain > 32'(MAX_BURST_BEATS)) begin
      return 5'(MAX_BURST_BEATS);
    end
    return remain[4:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmac_burst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmac_burst_gen                                         |
// | Description : Address / remaining-beat tracker for one AXI direction;|
// |               presents the next burst size and AXI len.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmac_burst_gen
  import dmac_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int BEAT_SIZE  = BEAT_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_beats,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN_WIDTH-1:0]  remain,
  output logic [4:0]            beats,
  output logic [3:0]            len
);

  assign beats = burst_beats(32'(remain));
  assign len   = 4'(beats - 5'd1);

  // Load a new job, or step past the burst just accepted by the slave.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr;
      remain <= load_beats;
    end else if (advance) begin
      addr   <= addr + ADDR_WIDTH'(beats) * ADDR_WIDTH'(BEAT_SIZE);
      remain <= remain - LEN_WIDTH'(beats);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmac_engine                                            |
// | Description : Single-channel DMA copy sequencer. AXI4 INCR reads     |
// |               fill an external show-ahead FIFO, AXI4 INCR writes     |
// |               drain it. Optional macro DMAC_ERR_EN adds rresp_i,     |
// |               bresp_i and a sticky err_o.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmac_engine
  import dmac_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH_LG2 = 4,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  byte_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [3:0]            arlen_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [3:0]            awlen_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_wren_o,
  output logic                  fifo_rden_o,
  output logic [DATA_WIDTH-1:0] fifo_wdata_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i
`ifdef DMAC_ERR_EN
  ,
  input  logic [1:0]            rresp_i,
  input  logic [1:0]            bresp_i,
  output logic                  err_o
`endif
);

  localparam int DEPTH      = 2 ** FIFO_DEPTH_LG2;
  localparam int CW         = FIFO_DEPTH_LG2 + 1;
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic                  busy, done;
  logic [CW-1:0]         fill_cnt, credit_cnt;
  logic [3:0]            wbeat_cnt;
  logic                  start_acc, load, ar_hs, aw_hs, w_hs, b_hs;
  logic [LEN_WIDTH-1:0]  len_beats;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [LEN_WIDTH-1:0]  rd_remain, wr_remain;
  logic [4:0]            rd_beats, wr_beats;
  logic [3:0]            rd_len, wr_len;

  assign len_beats = byte_len_i >> BEAT_SHIFT;
  assign start_acc = start_i & ~busy;
  assign load      = start_acc & (len_beats != '0);

  assign ar_hs = arvalid_o & arready_i;
  assign aw_hs = awvalid_o & awready_i;
  assign w_hs  = wvalid_o & wready_i;
  assign b_hs  = bvalid_i & bready_o;

  dmac_burst_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .BEAT_SIZE(DATA_WIDTH / 8)
  ) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .load(load), .load_addr(src_addr_i),
    .load_beats(len_beats), .advance(ar_hs), .addr(rd_addr),
    .remain(rd_remain), .beats(rd_beats), .len(rd_len)
  );

  dmac_burst_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .BEAT_SIZE(DATA_WIDTH / 8)
  ) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .load(load), .load_addr(dst_addr_i),
    .load_beats(len_beats), .advance(aw_hs), .addr(wr_addr),
    .remain(wr_remain), .beats(wr_beats), .len(wr_len)
  );

  assign busy_o       = busy;
  assign done_o       = done;
  assign araddr_o     = rd_addr;
  assign arlen_o      = rd_len;
  assign awaddr_o     = wr_addr;
  assign awlen_o      = wr_len;
  assign fifo_wren_o  = rvalid_i & rready_o;
  assign fifo_wdata_o = rdata_i;
  assign fifo_rden_o  = w_hs;
  assign wdata_o      = fifo_rdata_i;
  assign wlast_o      = wvalid_o & (wbeat_cnt == '0);

  // Job control: accept a start while idle; finish on the final write response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        busy <= (len_beats != '0);
        done <= (len_beats == '0);
      end else if (b_hs && wr_remain == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // State registers for the independent read and write sequencers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= RIDLE;
      wr_state <= WIDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // Read sequencer: only request a burst the FIFO is guaranteed to absorb.
  always_comb begin
    rd_next   = rd_state;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    case (rd_state)
      RIDLE: begin
        if (busy && rd_remain != '0 &&
            (32'(DEPTH) - 32'(credit_cnt)) >= 32'(rd_beats)) begin
          rd_next = RAR;
        end
      end
      RAR: begin
        arvalid_o = 1'b1;
        if (arready_i) rd_next = RDAT;
      end
      RDAT: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) rd_next = RIDLE;
      end
      default: rd_next = RIDLE;
    endcase
  end

  // Write sequencer: only issue a burst whose data is already in the FIFO.
  always_comb begin
    wr_next   = wr_state;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    case (wr_state)
      WIDLE: begin
        if (busy && wr_remain != '0 && 32'(fill_cnt) >= 32'(wr_beats)) begin
          wr_next = WAW;
        end
      end
      WAW: begin
        awvalid_o = 1'b1;
        if (awready_i) wr_next = WDAT;
      end
      WDAT: begin
        wvalid_o = 1'b1;
        if (wready_i && wbeat_cnt == '0) wr_next = WRSP;
      end
      WRSP: begin
        bready_o = 1'b1;
        if (bvalid_i) wr_next = WIDLE;
      end
      default: wr_next = WIDLE;
    endcase
  end

  // fill_cnt: unclaimed FIFO data; credit_cnt: FIFO slots reserved by reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt   <= '0;
      credit_cnt <= '0;
      wbeat_cnt  <= '0;
    end else begin
      fill_cnt   <= fill_cnt + CW'(fifo_wren_o) - (aw_hs ? CW'(wr_beats) : '0);
      credit_cnt <= credit_cnt + (ar_hs ? CW'(rd_beats) : '0) - CW'(fifo_rden_o);
      if (aw_hs) begin
        wbeat_cnt <= wr_len;
      end else if (w_hs && wbeat_cnt != '0) begin
        wbeat_cnt <= wbeat_cnt - 4'd1;
      end
    end
  end

`ifdef DMAC_ERR_EN
  logic err;
  logic resp_lsb_unused;
  assign resp_lsb_unused = rresp_i[0] ^ bresp_i[0];
  assign err_o = err;

  // Sticky error flag: any SLVERR/DECERR response; cleared by a new start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if ((fifo_wren_o && rresp_i[1]) || (b_hs && bresp_i[1])) begin
      err <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic [4:0] r_seen, r_exp;

  // Track R beats within the current read burst for the rlast check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen <= '0;
      r_exp  <= '0;
    end else if (ar_hs) begin
      r_seen <= '0;
      r_exp  <= rd_beats;
    end else if (fifo_wren_o) begin
      r_seen <= r_seen + 5'd1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wren_o && fifo_full_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rden_o && fifo_empty_i));
  a_rlast_pos: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_wren_o |-> (rlast_i == ((r_seen + 5'd1) == r_exp)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dmac_engine                                         |
// | Description : Self-checking bench: AXI slave + FIFO model, burst and |
// |               data scoreboard derived from the transfer parameters.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dmac_engine;
  localparam int DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [31:0] src_addr_i = '0, dst_addr_i = '0;
  logic [15:0] byte_len_i = '0;
  logic busy_o, done_o, arvalid_o, rready_o, awvalid_o, wlast_o, wvalid_o, bready_o;
  logic [31:0] araddr_o, awaddr_o, wdata_o, fifo_wdata_o;
  logic [3:0] arlen_o, awlen_o;
  logic arready_i = 0, rlast_i = 0, rvalid_i = 0, awready_i = 0, wready_i = 0, bvalid_i = 0;
  logic [31:0] rdata_i = '0, fifo_rdata_i = '0;
  logic fifo_full_i = 0, fifo_empty_i = 1, fifo_wren_o, fifo_rden_o;
`ifdef DMAC_ERR_EN
  logic [1:0] rresp_i = 2'b00, bresp_i = 2'b00;
  logic err_o;
`endif

  always #5 clk = ~clk;

  dmac_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i), .busy_o(busy_o), .done_o(done_o),
    .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .fifo_full_i(fifo_full_i),
    .fifo_empty_i(fifo_empty_i), .fifo_wren_o(fifo_wren_o), .fifo_rden_o(fifo_rden_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_rdata_i(fifo_rdata_i)
`ifdef DMAC_ERR_EN
    , .rresp_i(rresp_i), .bresp_i(bresp_i), .err_o(err_o)
`endif
  );

  typedef struct { logic [31:0] addr; int beats; } burst_t;

  int n_cmp = 0, n_err = 0;
  burst_t exp_ar[$], exp_aw[$], rd_q[$], wr_q[$], ar_log[$], aw_log[$];
  logic [31:0] exp_w[$], fifo_q[$];
  logic [31:0] dst_mem [logic [31:0]];
  int r_beat = 0, w_idx = 0, b_pending = 0, done_cnt = 0, max_fill = 0, wstall_cycles = 0;
  bit r_hold = 0, b_hold = 0, rnd_mode = 0, inject_bresp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  function automatic logic rnd_ok();
    return !rnd_mode || ($urandom_range(0, 3) != 0);
  endfunction

  // Split a job into bursts from the byte count alone.
  task automatic split(input logic [31:0] base, input int len, output burst_t q[$]);
    burst_t b;
    int rem = len / 4;
    logic [31:0] a = base;
    q.delete();
    while (rem > 0) begin
      b.addr = a; b.beats = (rem > 16) ? 16 : rem;
      q.push_back(b);
      a += 32'(4 * b.beats); rem -= b.beats;
    end
  endtask

  // Slave + FIFO + scoreboard: drive on negedge, evaluate the coming edge 1 ns later.
  initial begin
    forever begin
      @(negedge clk);
      fifo_full_i  = (fifo_q.size() >= DEPTH);
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
      arready_i = rnd_ok();
      awready_i = rnd_ok();
      if (wstall_cycles > 0) begin wready_i = 0; wstall_cycles--; end
      else wready_i = rnd_ok();
      if (!r_hold) begin
        rvalid_i = (rd_q.size() != 0) && rnd_ok();
        rdata_i  = rvalid_i ? src_word(rd_q[0].addr + 32'(4 * r_beat)) : 32'h0;
        rlast_i  = rvalid_i && (r_beat == rd_q[0].beats - 1);
      end
      if (!b_hold) bvalid_i = (b_pending > 0) && rnd_ok();
`ifdef DMAC_ERR_EN
      bresp_i = inject_bresp ? 2'b10 : 2'b00;
`endif
      #1;
      if (!rst_n) begin
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); rd_q.delete(); wr_q.delete();
        fifo_q.delete(); r_beat = 0; w_idx = 0; b_pending = 0; r_hold = 0; b_hold = 0;
        continue;
      end
      if (arvalid_o && arready_i) begin
        ar_log.push_back('{araddr_o, int'(arlen_o) + 1});
        check("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          check("araddr", araddr_o, exp_ar[0].addr);
          check("arlen", arlen_o, exp_ar[0].beats - 1);
          void'(exp_ar.pop_front());
        end
        rd_q.push_back('{araddr_o, int'(arlen_o) + 1});
      end
      if (rvalid_i && rready_o) begin
        r_beat++;
        if (rlast_i) begin void'(rd_q.pop_front()); r_beat = 0; end
      end
      r_hold = rvalid_i && !rready_o;
      if (fifo_wren_o) check("fifo_no_overflow", fifo_q.size() < DEPTH, 1);
      if (fifo_rden_o) check("fifo_no_underflow", fifo_q.size() > 0, 1);
      if (fifo_rden_o && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (fifo_wren_o) fifo_q.push_back(fifo_wdata_o);
      if (fifo_q.size() > max_fill) max_fill = fifo_q.size();
      if (awvalid_o && awready_i) begin
        aw_log.push_back('{awaddr_o, int'(awlen_o) + 1});
        check("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          check("awaddr", awaddr_o, exp_aw[0].addr);
          check("awlen", awlen_o, exp_aw[0].beats - 1);
          void'(exp_aw.pop_front());
        end
        wr_q.push_back('{awaddr_o, int'(awlen_o) + 1});
      end
      if (wvalid_o && wready_i) begin
        check("w_expected", exp_w.size() != 0 && wr_q.size() != 0, 1);
        if (exp_w.size() != 0) check("wdata", wdata_o, exp_w.pop_front());
        if (wr_q.size() != 0) begin
          dst_mem[wr_q[0].addr + 32'(4 * w_idx)] = wdata_o;
          w_idx++;
          check("wlast", wlast_o, w_idx == wr_q[0].beats);
          if (w_idx == wr_q[0].beats) begin void'(wr_q.pop_front()); w_idx = 0; b_pending++; end
        end
      end
      if (bvalid_i && bready_o) b_pending--;
      b_hold = bvalid_i && !bready_o;
      if (done_o) begin
        done_cnt++;
        check("busy_clear_with_done", busy_o, 0);
        check("done_after_all_data", exp_w.size(), 0);
      end
    end
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int len);
    @(negedge clk);
    split(s, len, exp_ar);
    split(d, len, exp_aw);
    exp_w.delete(); dst_mem.delete(); ar_log.delete(); aw_log.delete();
    for (int k = 0; k < len / 4; k++) exp_w.push_back(src_word(s + 32'(4 * k)));
    done_cnt = 0; max_fill = 0;
    src_addr_i = s; dst_addr_i = d; byte_len_i = 16'(len); start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    check({name, "_done_in_time"}, done_cnt != 0, 1);
    repeat (5) @(negedge clk);
    check({name, "_done_once"}, done_cnt, 1);
  endtask

  task automatic check_dst(input string name, input logic [31:0] s, input logic [31:0] d, input int len);
    int bad = 0;
    for (int k = 0; k < len / 4; k++) begin
      logic [31:0] a = d + 32'(4 * k);
      if (!dst_mem.exists(a) || dst_mem[a] !== src_word(s + 32'(4 * k))) bad++;
    end
    check({name, "_dst_mismatch_words"}, bad, 0);
    check({name, "_bursts_left"}, exp_ar.size() + exp_aw.size(), 0);
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return dst_mem.exists(a) ? dst_mem[a] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {busy_o, done_o, arvalid_o, awvalid_o, wvalid_o, wlast_o,
                            rready_o, bready_o, fifo_wren_o, fifo_rden_o}, 0);
    check("reset_addrs", {araddr_o, awaddr_o}, 0);
    @(negedge clk); rst_n = 1;

    // 1: single 64-byte copy, zero-wait slave
    kick(32'h1000, 32'h2000, 64);
    wait_done("t1", 2000);
    check_dst("t1", 32'h1000, 32'h2000, 64);
    check("t1_ar_count", ar_log.size(), 1);
    check("t1_ar0", {ar_log[0].addr, 32'(ar_log[0].beats)}, {32'h1000, 32'd16});
    check("t1_aw0", {aw_log[0].addr, 32'(aw_log[0].beats)}, {32'h2000, 32'd16});
    check("t1_first_word", mem_at(32'h2000), 32'hDEAD1000);
    check("t1_last_word", mem_at(32'h203C), 32'hDEAD103C);

    // 2: 200 bytes -> 16,16,16,2 beats
    kick(32'h3000, 32'h6000, 200);
    wait_done("t2", 4000);
    check_dst("t2", 32'h3000, 32'h6000, 200);
    check("t2_ar_count", ar_log.size(), 4);
    check("t2_ar3", {ar_log[3].addr, 32'(ar_log[3].beats)}, {32'h30C0, 32'd2});
    check("t2_aw1_addr", aw_log[1].addr, 32'h6040);
    check("t2_fill_bound", max_fill <= 16, 1);

    // 3: write data channel held off for 40 cycles mid-burst
    kick(32'h7000, 32'h8000, 128);
    n = 0;
    while (w_idx < 4 && n < 500) begin @(negedge clk); n++; end
    check("t3_reached_w", w_idx >= 4, 1);
    wstall_cycles = 40;
    repeat (35) @(negedge clk);
    check("t3_reads_stalled", ar_log.size(), 1);
    wait_done("t3", 4000);
    check_dst("t3", 32'h7000, 32'h8000, 128);
    check("t3_fill_peak", max_fill, 16);

    // 4: random stalls, 1 KB, plus a start pulse while busy that must be ignored
    rnd_mode = 1;
    kick(32'h10000, 32'h20000, 1024);
    repeat (50) @(negedge clk);
    check("t4_busy", busy_o, 1);
    src_addr_i = 32'h9000; dst_addr_i = 32'hA000; byte_len_i = 16'd64; start_i = 1;
    @(negedge clk); start_i = 0;
    wait_done("t4", 20000);
    check_dst("t4", 32'h10000, 32'h20000, 1024);
    rnd_mode = 0;

    // 5: zero-length job
    @(negedge clk);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); ar_log.delete(); aw_log.delete();
    done_cnt = 0;
    byte_len_i = 0; start_i = 1;
    @(posedge clk); #1;
    check("t5_done_pulse", {done_o, busy_o}, 2'b10);
    @(negedge clk); start_i = 0;
    @(posedge clk); #1;
    check("t5_done_drop", done_o, 0);
    repeat (5) @(negedge clk);
    check("t5_no_axi", ar_log.size() + aw_log.size(), 0);
    check("t5_done_once", done_cnt, 1);

    // 6: reset mid-transfer, then a fresh job must complete
    rnd_mode = 1;
    kick(32'h4000, 32'h5000, 512);
    repeat (30) @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    check("t6_valids_after_rst", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, busy_o}, 0);
    @(negedge clk); rst_n = 1;
    rnd_mode = 0;
    kick(32'hC000, 32'hD000, 256);
    wait_done("t6", 4000);
    check_dst("t6", 32'hC000, 32'hD000, 256);

`ifdef DMAC_ERR_EN
    inject_bresp = 1;
    kick(32'h1000, 32'h2000, 64);
    wait_done("terr", 2000);
    inject_bresp = 0;
    check("err_set", err_o, 1);
    repeat (10) @(negedge clk);
    check("err_sticky", err_o, 1);
    kick(32'h1000, 32'h2000, 64);
    check("err_cleared_on_start", err_o, 0);
    wait_done("terr2", 2000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
